// File: rtl/ipv4_pkg.sv
// Shared types for the IPv4 header framer and its checksum sub-module.
package ipv4_pkg;

    localparam int IPV4_HDR_BYTES = 20;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEADER  = 2'd1,
        PAYLOAD = 2'd2
    } framer_state_t;

    typedef struct packed {
        logic [7:0]  version;
        logic [7:0]  service_type;
        logic [15:0] length;
        logic [15:0] identification;
        logic [15:0] flags_frag;
        logic [7:0]  ttl;
        logic [7:0]  protocol;
        logic [31:0] src;
        logic [31:0] dst;
    } ipv4_hdr_t;

    // Addresses go out as [23:16], [31:24], [7:0], [15:8]
    function automatic logic [7:0] ip_wire_byte(
        input logic [31:0] ip,
        input logic [1:0]  k
    );
        logic [7:0] b;
        case (k)
            2'd0:    b = ip[23:16];
            2'd1:    b = ip[31:24];
            2'd2:    b = ip[7:0];
            default: b = ip[15:8];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/ipv4_checksum_calculator.sv
// Combinational IPv4 header checksum over the latched header fields.
module ipv4_checksum_calculator
    import ipv4_pkg::*;
(
    input  ipv4_hdr_t   i_hdr,
    output logic [15:0] o_checksum
);

    logic [19:0] w_sum;
    logic [16:0] w_fold1;
    logic [16:0] w_fold2;

    // Words are summed in wire byte order, checksum field taken as zero
    assign w_sum = 20'({i_hdr.version, i_hdr.service_type})
                 + 20'(i_hdr.length)
                 + 20'(i_hdr.identification)
                 + 20'(i_hdr.flags_frag)
                 + 20'({i_hdr.ttl, i_hdr.protocol})
                 + 20'({i_hdr.src[23:16], i_hdr.src[31:24]})
                 + 20'({i_hdr.src[7:0], i_hdr.src[15:8]})
                 + 20'({i_hdr.dst[23:16], i_hdr.dst[31:24]})
                 + 20'({i_hdr.dst[7:0], i_hdr.dst[15:8]});

    assign w_fold1 = 17'(w_sum[15:0]) + 17'(w_sum[19:16]);
    assign w_fold2 = 17'(w_fold1[15:0]) + 17'(w_fold1[16]);
    assign o_checksum = ~w_fold2[15:0];

endmodule

// File: rtl/ipv4_header_framer.sv
// IPv4 framer: 20-byte header with checksum, then payload pass-through.
// Define IPV4_FRAMER_LENGTH_CHECK_EN to enable the payload length check.
module ipv4_header_framer
    import ipv4_pkg::*;
#(
    parameter int COUNT_W = 16
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        HDR_VALID,
    output logic        HDR_READY,
    input  logic [7:0]  VERSION,
    input  logic [7:0]  SERVICE_TYPE,
    input  logic [15:0] LENGTH,
    input  logic [15:0] IDENTIFICATION,
    input  logic [15:0] FLAGS_AND_FRAGMENT,
    input  logic [7:0]  TTL,
    input  logic [7:0]  PROTOCOL,
    input  logic [31:0] SRC_IP_ADDRESS,
    input  logic [31:0] DST_IP_ADDRESS,
    input  logic [7:0]  PAYLOAD_TDATA,
    input  logic        PAYLOAD_TVALID,
    output logic        PAYLOAD_TREADY,
    input  logic        PAYLOAD_TLAST,
    output logic [7:0]  OUT_TDATA,
    output logic        OUT_TVALID,
    input  logic        OUT_TREADY,
    output logic        OUT_TLAST,
    output logic        BUSY,
    output logic        LENGTH_ERR
);

    if (COUNT_W < 16) begin : g_count_w_check
        $error("COUNT_W must be at least 16");
    end

    framer_state_t r_state;
    ipv4_hdr_t     r_hdr;
    logic [4:0]    r_byte_idx;
    logic          r_ready_en;

    ipv4_hdr_t     w_hdr_in;
    logic [15:0]   w_checksum;
    logic [7:0]    w_hdr_byte;
    logic          w_hdr_fire;
    logic          w_out_fire;
    logic          w_pay_fire;
    logic          w_last_byte;
    logic          w_hdr_only;

    assign w_hdr_in = {VERSION, SERVICE_TYPE, LENGTH, IDENTIFICATION,
                       FLAGS_AND_FRAGMENT, TTL, PROTOCOL,
                       SRC_IP_ADDRESS, DST_IP_ADDRESS};

    ipv4_checksum_calculator u_csum (
        .i_hdr      (r_hdr),
        .o_checksum (w_checksum)
    );

    // Ready is held off for the first cycle out of reset
    assign HDR_READY   = r_ready_en && (r_state == IDLE);
    assign BUSY        = (r_state != IDLE);
    assign w_hdr_fire  = HDR_VALID && HDR_READY;
    assign w_out_fire  = OUT_TVALID && OUT_TREADY;
    assign w_pay_fire  = PAYLOAD_TVALID && PAYLOAD_TREADY;
    assign w_last_byte = (r_byte_idx == 5'(IPV4_HDR_BYTES - 1));
    assign w_hdr_only  = (r_hdr.length <= 16'(IPV4_HDR_BYTES));

    always_comb begin
        w_hdr_byte = 8'h00;
        case (r_byte_idx)
            5'd0:  w_hdr_byte = r_hdr.version;
            5'd1:  w_hdr_byte = r_hdr.service_type;
            5'd2:  w_hdr_byte = r_hdr.length[15:8];
            5'd3:  w_hdr_byte = r_hdr.length[7:0];
            5'd4:  w_hdr_byte = r_hdr.identification[15:8];
            5'd5:  w_hdr_byte = r_hdr.identification[7:0];
            5'd6:  w_hdr_byte = r_hdr.flags_frag[15:8];
            5'd7:  w_hdr_byte = r_hdr.flags_frag[7:0];
            5'd8:  w_hdr_byte = r_hdr.ttl;
            5'd9:  w_hdr_byte = r_hdr.protocol;
            5'd10: w_hdr_byte = w_checksum[15:8];
            5'd11: w_hdr_byte = w_checksum[7:0];
            5'd12, 5'd13, 5'd14, 5'd15:
                w_hdr_byte = ip_wire_byte(r_hdr.src, r_byte_idx[1:0]);
            5'd16, 5'd17, 5'd18, 5'd19:
                w_hdr_byte = ip_wire_byte(r_hdr.dst, r_byte_idx[1:0]);
            default: w_hdr_byte = 8'h00;
        endcase
    end

    always_comb begin
        OUT_TVALID     = 1'b0;
        OUT_TDATA      = 8'h00;
        OUT_TLAST      = 1'b0;
        PAYLOAD_TREADY = 1'b0;
        unique case (r_state)
            HEADER: begin
                OUT_TVALID = 1'b1;
                OUT_TDATA  = w_hdr_byte;
                OUT_TLAST  = w_last_byte && w_hdr_only;
            end
            PAYLOAD: begin
                OUT_TVALID     = PAYLOAD_TVALID;
                OUT_TDATA      = PAYLOAD_TDATA;
                OUT_TLAST      = PAYLOAD_TLAST;
                PAYLOAD_TREADY = OUT_TREADY;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state    <= IDLE;
            r_hdr      <= '0;
            r_byte_idx <= 5'd0;
            r_ready_en <= 1'b0;
        end else begin
            r_ready_en <= 1'b1;
            unique case (r_state)
                IDLE: begin
                    if (w_hdr_fire) begin
                        r_hdr      <= w_hdr_in;
                        r_byte_idx <= 5'd0;
                        r_state    <= HEADER;
                    end
                end
                HEADER: begin
                    if (w_out_fire) begin
                        if (w_last_byte) begin
                            r_state <= w_hdr_only ? IDLE : PAYLOAD;
                        end else begin
                            r_byte_idx <= r_byte_idx + 5'd1;
                        end
                    end
                end
                PAYLOAD: begin
                    if (w_pay_fire && PAYLOAD_TLAST) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef IPV4_FRAMER_LENGTH_CHECK_EN
    logic [COUNT_W-1:0] r_beat_cnt;
    logic               r_len_err;
    logic [COUNT_W-1:0] w_beat_next;
    logic [COUNT_W-1:0] w_beat_exp;

    assign w_beat_next = r_beat_cnt + COUNT_W'(1);
    assign w_beat_exp  = COUNT_W'(r_hdr.length) - COUNT_W'(IPV4_HDR_BYTES);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_beat_cnt <= '0;
            r_len_err  <= 1'b0;
        end else begin
            r_len_err <= 1'b0;
            if (w_hdr_fire) begin
                r_beat_cnt <= '0;
            end
            if ((r_state == HEADER) && w_out_fire && w_last_byte
                && (r_hdr.length < 16'(IPV4_HDR_BYTES))) begin
                r_len_err <= 1'b1;
            end
            if (w_pay_fire) begin
                r_beat_cnt <= w_beat_next;
                if (PAYLOAD_TLAST && (w_beat_next != w_beat_exp)) begin
                    r_len_err <= 1'b1;
                end
            end
        end
    end

    assign LENGTH_ERR = r_len_err;
`else
    assign LENGTH_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_ipv4_header_framer.sv
// Scoreboard bench for ipv4_header_framer: directed packets, backpressure, reset.
module tb_ipv4_header_framer;

    typedef struct packed {
        logic [7:0]  ver;
        logic [7:0]  svc;
        logic [15:0] len;
        logic [15:0] id;
        logic [15:0] flg;
        logic [7:0]  ttl;
        logic [7:0]  proto;
        logic [31:0] src;
        logic [31:0] dst;
        logic [15:0] csum;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        hdr_valid;
    logic        hdr_ready;
    logic [7:0]  version, service_type, ttl, protocol;
    logic [15:0] length, identification, flags_frag;
    logic [31:0] src_ip, dst_ip;
    logic [7:0]  pay_tdata;
    logic        pay_tvalid, pay_tready, pay_tlast;
    logic [7:0]  out_tdata;
    logic        out_tvalid, out_tready, out_tlast;
    logic        busy, length_err;

    ipv4_header_framer #(.COUNT_W(16)) dut (
        .CLK                (clk),
        .RESET_N            (rst_n),
        .HDR_VALID          (hdr_valid),
        .HDR_READY          (hdr_ready),
        .VERSION            (version),
        .SERVICE_TYPE       (service_type),
        .LENGTH             (length),
        .IDENTIFICATION     (identification),
        .FLAGS_AND_FRAGMENT (flags_frag),
        .TTL                (ttl),
        .PROTOCOL           (protocol),
        .SRC_IP_ADDRESS     (src_ip),
        .DST_IP_ADDRESS     (dst_ip),
        .PAYLOAD_TDATA      (pay_tdata),
        .PAYLOAD_TVALID     (pay_tvalid),
        .PAYLOAD_TREADY     (pay_tready),
        .PAYLOAD_TLAST      (pay_tlast),
        .OUT_TDATA          (out_tdata),
        .OUT_TVALID         (out_tvalid),
        .OUT_TREADY         (out_tready),
        .OUT_TLAST          (out_tlast),
        .BUSY               (busy),
        .LENGTH_ERR         (length_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int beat_cnt = 0;
    int tlast_cnt = 0;
    int tlast_cyc = 0;
    int hs_cnt = 0;
    int hs_cyc = 0;
    int err_cnt = 0;
    int err_cyc = 0;
    bit prt_seen = 0;
    bit prev_stall = 0;
    bit rand_mode = 0;
    bit st11 = 0;
    logic [8:0] prev_beat;
    logic [8:0] sb[$];

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        if (rand_mode) begin
            if (beat_cnt == 11 && !st11) begin
                out_tready = 1'b0;
                st11 = 1'b1;
            end else begin
                out_tready = 1'($urandom_range(0, 1));
            end
        end else begin
            out_tready = 1'b1;
        end
    end

    always @(negedge clk) begin
        logic [8:0] exp;
        if (!rst_n) begin
            prev_stall = 1'b0;
            beat_cnt = 0;
        end else begin
            if (prev_stall) chk("stall_hold", {out_tlast, out_tdata}, prev_beat);
            if (out_tvalid && out_tready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_beat", 0, 1);
                end else begin
                    exp = sb.pop_front();
                    chk("out_beat", {out_tlast, out_tdata}, exp);
                end
                beat_cnt++;
                if (out_tlast) begin
                    tlast_cnt++;
                    tlast_cyc = cyc;
                    beat_cnt = 0;
                end
            end
            prev_stall = out_tvalid && !out_tready;
            prev_beat = {out_tlast, out_tdata};
            if (pay_tready) prt_seen = 1'b1;
            if (hdr_valid && hdr_ready) begin
                hs_cnt++;
                hs_cyc = cyc;
            end
            if (length_err) begin
                err_cnt++;
                err_cyc = cyc;
            end
        end
    end

    function automatic void push_hdr(vec_t v);
        logic [7:0] b [20];
        b[0] = v.ver;        b[1] = v.svc;
        b[2] = v.len[15:8];  b[3] = v.len[7:0];
        b[4] = v.id[15:8];   b[5] = v.id[7:0];
        b[6] = v.flg[15:8];  b[7] = v.flg[7:0];
        b[8] = v.ttl;        b[9] = v.proto;
        b[10] = v.csum[15:8]; b[11] = v.csum[7:0];
        b[12] = v.src[23:16]; b[13] = v.src[31:24];
        b[14] = v.src[7:0];   b[15] = v.src[15:8];
        b[16] = v.dst[23:16]; b[17] = v.dst[31:24];
        b[18] = v.dst[7:0];   b[19] = v.dst[15:8];
        for (int i = 0; i < 20; i++)
            sb.push_back({(i == 19) && (v.len <= 16'd20), b[i]});
    endfunction

    function automatic void push_pay(int n_total, int n_push, logic [7:0] base);
        for (int i = 0; i < n_push; i++)
            sb.push_back({i == n_total - 1, 8'(base + 8'(i))});
    endfunction

    task automatic set_fields(vec_t v);
        version = v.ver; service_type = v.svc; length = v.len;
        identification = v.id; flags_frag = v.flg;
        ttl = v.ttl; protocol = v.proto; src_ip = v.src; dst_ip = v.dst;
    endtask

    task automatic scramble_fields();
        version = 8'hA5; service_type = 8'h5A; length = 16'hFFFF;
        identification = 16'h1234; flags_frag = 16'hBEEF;
        ttl = 8'h01; protocol = 8'h02; src_ip = '1; dst_ip = '0;
    endtask

    task automatic drive_hdr(vec_t v);
        int h0 = hs_cnt;
        set_fields(v);
        hdr_valid = 1'b1;
        for (int i = 0; i < 2000 && hs_cnt == h0; i++) @(posedge clk);
        chk("hdr_accept", 32'(hs_cnt != h0), 1);
        #1;
        hdr_valid = 1'b0;
        scramble_fields();
    endtask

    task automatic drive_pay(int n_total, int n_send, logic [7:0] base);
        bit acc;
        for (int i = 0; i < n_send; i++) begin
            pay_tdata = 8'(base + 8'(i));
            pay_tlast = (i == n_total - 1);
            pay_tvalid = 1'b1;
            acc = 1'b0;
            for (int k = 0; k < 2000 && !acc; k++) begin
                @(negedge clk);
                acc = pay_tready;
                @(posedge clk);
            end
            chk("pay_accept", 32'(acc), 1);
            #1;
        end
        pay_tvalid = 1'b0;
        pay_tlast = 1'b0;
    endtask

    task automatic wait_tlast(int k);
        for (int i = 0; i < 4000 && tlast_cnt < k; i++) @(posedge clk);
        chk("tlast_wait", 32'(tlast_cnt >= k), 1);
    endtask

    vec_t v_main, v_hdr20, v_len32, v_len16;
    int e0, h0, hcyc, tcyc;

    initial begin
        v_main  = '{8'h45, 8'h00, 16'h0073, 16'h0000, 16'h4000, 8'h40, 8'h11,
                    32'hA8C00100, 32'hA8C0C700, 16'hB861};
        v_hdr20 = v_main; v_hdr20.len = 16'h0014; v_hdr20.csum = 16'hB8C0;
        v_len32 = v_main; v_len32.len = 16'h0020; v_len32.csum = 16'hB8B4;
        v_len16 = v_main; v_len16.len = 16'h0010; v_len16.csum = 16'hB8C4;

        rst_n = 1'b0; hdr_valid = 1'b0; out_tready = 1'b1;
        pay_tdata = 8'h00; pay_tvalid = 1'b0; pay_tlast = 1'b0;
        scramble_fields();
        repeat (2) @(negedge clk);
        chk("rst_hdr_ready", 32'(hdr_ready), 0);
        chk("rst_out_tvalid", 32'(out_tvalid), 0);
        chk("rst_out_tlast", 32'(out_tlast), 0);
        chk("rst_out_tdata", 32'(out_tdata), 0);
        chk("rst_pay_tready", 32'(pay_tready), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_length_err", 32'(length_err), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("ready_before_edge", 32'(hdr_ready), 0);
        @(negedge clk);
        chk("ready_after_release", 32'(hdr_ready), 1);

        // checksum and byte order
        push_hdr(v_main);
        push_pay(95, 95, 8'h10);
        drive_hdr(v_main);
        @(negedge clk);
        chk("first_byte_latency", 32'(out_tvalid), 1);
        chk("busy_in_header", 32'(busy), 1);
        drive_pay(95, 95, 8'h10);
        wait_tlast(1);

        // random backpressure with forced stall on byte 11
        rand_mode = 1'b1; st11 = 1'b0;
        push_hdr(v_main);
        push_pay(95, 95, 8'h80);
        drive_hdr(v_main);
        drive_pay(95, 95, 8'h80);
        wait_tlast(2);
        rand_mode = 1'b0;

        // header-only packet
        prt_seen = 1'b0;
        push_hdr(v_hdr20);
        drive_hdr(v_hdr20);
        wait_tlast(3);
        @(negedge clk);
        chk("hdr_only_ready_back", 32'(hdr_ready), 1);
        chk("hdr_only_no_pay_ready", 32'(prt_seen), 0);

        // back-to-back with HDR_VALID held
        push_hdr(v_len32); push_pay(12, 12, 8'hA0);
        push_hdr(v_len32); push_pay(12, 12, 8'hB0);
        h0 = hs_cnt;
        fork
            begin
                set_fields(v_len32);
                hdr_valid = 1'b1;
                for (int i = 0; i < 2000 && hs_cnt < h0 + 2; i++) @(posedge clk);
                hcyc = hs_cyc; tcyc = tlast_cyc;
                #1 hdr_valid = 1'b0;
            end
            begin
                drive_pay(12, 12, 8'hA0);
                drive_pay(12, 12, 8'hB0);
            end
        join
        chk("b2b_two_headers", 32'(hs_cnt - h0), 2);
        chk("b2b_gap", 32'(hcyc - tcyc), 1);
        wait_tlast(5);

        // reset in the middle of the payload
        e0 = err_cnt;
        push_hdr(v_len32);
        push_pay(12, 6, 8'hC0);
        drive_hdr(v_len32);
        drive_pay(12, 5, 8'hC0);
        pay_tdata = 8'hC5; pay_tvalid = 1'b1; pay_tlast = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_tvalid", 32'(out_tvalid), 0);
        chk("mid_rst_out_tdata", 32'(out_tdata), 0);
        chk("mid_rst_out_tlast", 32'(out_tlast), 0);
        chk("mid_rst_pay_tready", 32'(pay_tready), 0);
        chk("mid_rst_hdr_ready", 32'(hdr_ready), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_sb_drained", sb.size(), 0);
        sb.delete();
        pay_tvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        push_hdr(v_len32);
        push_pay(12, 12, 8'hD0);
        drive_hdr(v_len32);
        drive_pay(12, 12, 8'hD0);
        wait_tlast(6);
        repeat (2) @(negedge clk);
        chk("post_rst_no_err", err_cnt - e0, 0);

`ifdef IPV4_FRAMER_LENGTH_CHECK_EN
        // short payload: one pulse the cycle after TLAST
        e0 = err_cnt;
        push_hdr(v_len32);
        push_pay(11, 11, 8'hE0);
        drive_hdr(v_len32);
        drive_pay(11, 11, 8'hE0);
        wait_tlast(7);
        repeat (3) @(negedge clk);
        chk("len11_err_pulses", err_cnt - e0, 1);
        chk("len11_err_timing", err_cyc - tlast_cyc, 1);

        e0 = err_cnt;
        push_hdr(v_len32);
        push_pay(12, 12, 8'hF0);
        drive_hdr(v_len32);
        drive_pay(12, 12, 8'hF0);
        wait_tlast(8);
        repeat (3) @(negedge clk);
        chk("len12_no_err", err_cnt - e0, 0);

        // LENGTH below header size
        e0 = err_cnt;
        push_hdr(v_len16);
        drive_hdr(v_len16);
        wait_tlast(9);
        repeat (3) @(negedge clk);
        chk("len16_err_pulses", err_cnt - e0, 1);
        chk("len16_err_timing", err_cyc - tlast_cyc, 1);
`else
        chk("no_length_err_default", err_cnt, 0);
`endif

        repeat (3) @(negedge clk);
        chk("sb_empty_at_end", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
